// File: rtl/matriz_seta_varredura.sv
// Column-scan controller for the 5x7 elevator direction LED matrix.
// Optional blink of the arrow symbols is built in when SETA_PISCA_EN is defined.
module matriz_seta_varredura #(
  parameter int DIV           = 50000,
  parameter int PISCA_QUADROS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] sentido,
  output logic [4:0] colunas,
  output logic [6:0] linhas,
  output logic       fim_quadro
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cont;
  logic [2:0]    col_idx;
  logic [1:0]    simbolo_reg;
  logic          tick;
  logic          fim_frame;
  logic          apaga;
  logic [6:0]    padrao;

  assign tick      = (cont == CW'(DIV - 1));
  assign fim_frame = enable && tick && (col_idx == 3'd4);

  // Glyph table: bit r of the column vector lights row r
  always_comb begin
    padrao = 7'h00;
    case (simbolo_reg)
      2'b01: begin
        case (col_idx)
          3'd0, 3'd4: padrao = 7'h04;
          3'd1, 3'd3: padrao = 7'h06;
          3'd2:       padrao = 7'h7F;
          default:    padrao = 7'h00;
        endcase
      end
      2'b10: begin
        case (col_idx)
          3'd0, 3'd4: padrao = 7'h10;
          3'd1, 3'd3: padrao = 7'h30;
          3'd2:       padrao = 7'h7F;
          default:    padrao = 7'h00;
        endcase
      end
      2'b00:   padrao = 7'h08;
      default: padrao = 7'h00;
    endcase
  end

  // Symbol only changes at the frame boundary so the image never tears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cont        <= '0;
      col_idx     <= 3'd0;
      simbolo_reg <= 2'b11;
    end else if (!enable) begin
      cont        <= '0;
      col_idx     <= 3'd0;
      simbolo_reg <= sentido;
    end else begin
      if (tick) begin
        cont    <= '0;
        col_idx <= (col_idx == 3'd4) ? 3'd0 : col_idx + 3'd1;
        if (col_idx == 3'd4) simbolo_reg <= sentido;
      end else begin
        cont <= cont + CW'(1);
      end
    end
  end

`ifdef SETA_PISCA_EN
  localparam int QN = 2 * PISCA_QUADROS;
  localparam int QW = (QN > 1) ? $clog2(QN) : 1;

  logic [QW-1:0] quadro;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quadro <= '0;
    end else if (!enable) begin
      quadro <= '0;
    end else if (fim_frame) begin
      quadro <= (quadro == QW'(QN - 1)) ? '0 : quadro + QW'(1);
    end
  end

  assign apaga = ((simbolo_reg == 2'b01) || (simbolo_reg == 2'b10)) &&
                 (quadro >= QW'(PISCA_QUADROS));
`else
  // Arrows are steady; the blink period only matters in the blink build
  assign apaga = (PISCA_QUADROS < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      colunas    <= 5'b00000;
      linhas     <= 7'h7F;
      fim_quadro <= 1'b0;
    end else if (!enable) begin
      colunas    <= 5'b00000;
      linhas     <= 7'h7F;
      fim_quadro <= 1'b0;
    end else begin
      colunas    <= 5'b00001 << col_idx;
      linhas     <= apaga ? 7'h7F : ~padrao;
      fim_quadro <= fim_frame;
    end
  end

endmodule

// File: tb/tb_matriz_seta_varredura.sv
// Bench for matriz_seta_varredura: directed steps plus random sentido/enable,
// checked against a frame-position model of the display.
module tb_matriz_seta_varredura;

  localparam int DIV   = 4;
  localparam int PQ    = 2;
  localparam int FRAME = 5 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] sentido;
  logic [4:0] colunas;
  logic [6:0] linhas;
  logic       fim_quadro;

  int compared   = 0;
  int mismatched = 0;

  int         pos;
  logic [1:0] sym;
  logic [4:0] exp_col;
  logic [6:0] exp_lin;
  logic       exp_fim;

  matriz_seta_varredura #(.DIV(DIV), .PISCA_QUADROS(PQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sentido    (sentido),
    .colunas    (colunas),
    .linhas     (linhas),
    .fim_quadro (fim_quadro)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [1:0] s, input int c);
    case (s)
      2'b01:   return (c == 0 || c == 4) ? 7'h04 : (c == 2) ? 7'h7F : 7'h06;
      2'b10:   return (c == 0 || c == 4) ? 7'h10 : (c == 2) ? 7'h7F : 7'h30;
      2'b00:   return 7'h08;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic blinkOff(input int p, input logic [1:0] s);
`ifdef SETA_PISCA_EN
    return ((s == 2'b01) || (s == 2'b10)) && (((p / FRAME) / PQ) % 2 == 1);
`else
    return 1'b0;
`endif
  endfunction

  // Model: pos counts enabled cycles since the scan (re)started
  task automatic modelEdge();
    int c;
    if (reset) begin
      pos = 0; sym = 2'b11;
      exp_col = 5'b0; exp_lin = 7'h7F; exp_fim = 1'b0;
    end else if (!enable) begin
      pos = 0; sym = sentido;
      exp_col = 5'b0; exp_lin = 7'h7F; exp_fim = 1'b0;
    end else begin
      c       = (pos / DIV) % 5;
      exp_col = 5'(1 << c);
      exp_lin = blinkOff(pos, sym) ? 7'h7F : ~glyph(sym, c);
      exp_fim = ((pos % FRAME) == FRAME - 1);
      if (exp_fim) sym = sentido;
      pos++;
    end
  endtask

  task automatic checkOutput(input string tag);
    compared++;
    assert (colunas === exp_col) else begin
      mismatched++;
      $error("[TB] FAIL %s.colunas observed=%b expected=%b", tag, colunas, exp_col);
    end
    compared++;
    assert (linhas === exp_lin) else begin
      mismatched++;
      $error("[TB] FAIL %s.linhas observed=%h expected=%h", tag, linhas, exp_lin);
    end
    compared++;
    assert (fim_quadro === exp_fim) else begin
      mismatched++;
      $error("[TB] FAIL %s.fim_quadro observed=%b expected=%b", tag, fim_quadro, exp_fim);
    end
  endtask

  task automatic checkConst(input string tag, input logic [4:0] c, input logic [6:0] l);
    compared++;
    assert (colunas === c && linhas === l) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b/%h expected=%b/%h", tag, colunas, linhas, c, l);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] sen, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      enable  = en;
      sentido = sen;
      @(posedge clk);
      modelEdge();
      #1 checkOutput(tag);
    end
  endtask

  initial begin
    logic       en;
    logic [1:0] sen;
    int         guard;

    reset = 1'b1; enable = 1'b0; sentido = 2'b01;
    pos = 0; sym = 2'b11;
    exp_col = 5'b0; exp_lin = 7'h7F; exp_fim = 1'b0;
    #2 checkConst("reset_state", 5'b00000, 7'h7F);
    applyStimulus(1'b0, 2'b01, 2, "reset_hold");
    reset = 1'b0;
    applyStimulus(1'b0, 2'b01, 2, "disabled");

    applyStimulus(1'b1, 2'b01, 1, "first_col");
    checkConst("up_col0", 5'b00001, 7'h7B);
    applyStimulus(1'b1, 2'b01, 44, "up_scan");

    guard = 0;
    while ((pos % FRAME) != 2 * DIV && guard < 100) begin
      applyStimulus(1'b1, 2'b01, 1, "to_col2");
      guard++;
    end
    applyStimulus(1'b1, 2'b10, 45, "mid_change");

    applyStimulus(1'b1, 2'b00, 45, "parado");
    applyStimulus(1'b1, 2'b11, 45, "apagado");

    guard = 0;
    while ((pos % FRAME) != FRAME - 1 && guard < 100) begin
      applyStimulus(1'b1, 2'b11, 1, "to_boundary");
      guard++;
    end
    applyStimulus(1'b1, 2'b01, 25, "edge_capture");

    guard = 0;
    while (((pos / DIV) % 5) != 3 && guard < 100) begin
      applyStimulus(1'b1, 2'b01, 1, "to_col3");
      guard++;
    end
    applyStimulus(1'b1, 2'b01, 2, "col3");
    applyStimulus(1'b0, 2'b10, 1, "enable_drop");
    checkConst("dark", 5'b00000, 7'h7F);
    applyStimulus(1'b0, 2'b10, 3, "dark_hold");
    applyStimulus(1'b1, 2'b10, 1, "reenable");
    checkConst("reenable_col0", 5'b00001, 7'h6F);
    applyStimulus(1'b1, 2'b10, 30, "reenable_run");

    // Asynchronous reset between edges must clear outputs immediately
    @(posedge clk);
    modelEdge();
    #3 reset = 1'b1;
    pos = 0; sym = 2'b11;
    exp_col = 5'b0; exp_lin = 7'h7F; exp_fim = 1'b0;
    #1 checkOutput("async_reset");
    applyStimulus(1'b1, 2'b01, 2, "reset_mid");
    reset = 1'b0;
    applyStimulus(1'b1, 2'b01, 45, "after_reset");

    sen = 2'b01;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 9) == 0) sen = 2'($urandom_range(0, 3));
      applyStimulus(en, sen, 1, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
